// File: rtl/tx_burst_scheduler.sv
// Round-robin burst scheduler sharing one 64-bit lane transmit path among NUM_CH sources.
// One channel owns the lane per burst; a burst ends on end-of-packet or after BURST_MAX words.
module tx_burst_scheduler #(
  parameter int  NUM_CH    = 4,
  parameter int  BURST_MAX = 8,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int CNT_W     = $clog2(BURST_MAX)
) (
  input  logic                   USER_CLK,
  input  logic                   SYSTEM_RESET_N,
  input  logic                   TX_ENABLE,
  input  logic [64*NUM_CH-1:0]   CH_DATA,
  input  logic [NUM_CH-1:0]      CH_VALID,
  input  logic [NUM_CH-1:0]      CH_LAST,
  output logic [NUM_CH-1:0]      CH_READY,
  output logic [63:0]            DATA_OUT,
  output logic                   DATA_TO_SEND,
  input  logic                   DATA_IN_READY,
  output logic [CH_W-1:0]        BURST_CH,
  output logic                   BURST_SOP,
  output logic                   BURST_EOP,
  output logic                   BUSY
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  grant, grant_nxt;
  logic [CH_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             sop_pend, sop_pend_nxt;

  logic [63:0]      ch_word [NUM_CH];
  logic [CH_W-1:0]  arb_ch, cand;
  logic             arb_hit;
  logic             in_burst, xfer, eop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_word[i] = CH_DATA[64*i +: 64];
  end

  // Scan from the farthest candidate back to rr_ptr+1 so the nearest valid channel wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    arb_ch  = '0;
    arb_hit = 1'b0;
    cand    = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = CH_W'((int'(rr_ptr) + off) % NUM_CH);
      if (CH_VALID[cand]) begin
        arb_ch  = cand;
        arb_hit = 1'b1;
      end
    end
  end

  assign in_burst = (state == BURST);
  assign xfer     = in_burst && CH_VALID[grant] && DATA_IN_READY;
  assign eop      = xfer && (CH_LAST[grant] || (burst_cnt == CNT_W'(BURST_MAX - 1)));

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    sop_pend_nxt  = sop_pend;
    unique case (state)
      IDLE: begin
        if (TX_ENABLE && arb_hit) begin
          grant_nxt     = arb_ch;
          burst_cnt_nxt = '0;
          sop_pend_nxt  = 1'b1;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          sop_pend_nxt  = 1'b0;
          if (eop) begin
            // The finishing channel becomes lowest priority for the next arbitration.
            rr_ptr_nxt = grant;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      burst_cnt <= '0;
      sop_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      sop_pend  <= sop_pend_nxt;
    end
  end

  always_comb begin
    CH_READY = '0;
    if (in_burst) CH_READY[grant] = CH_VALID[grant] & DATA_IN_READY;
  end

  assign DATA_OUT     = ch_word[grant];
  assign DATA_TO_SEND = in_burst && CH_VALID[grant];
  assign BURST_CH     = grant;
  assign BURST_SOP    = xfer && sop_pend;
  assign BURST_EOP    = eop;
  assign BUSY         = in_burst;

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Self-checking bench for tx_burst_scheduler: vector table, directed corner sequences and
// randomized traffic scored against a burst-level reference model.
module tb_tx_burst_scheduler;

  localparam int NUM_CH    = 4;
  localparam int BURST_MAX = 8;
  localparam int CH_W      = $clog2(NUM_CH);

  logic                 user_clk = 1'b0;
  logic                 rst_n;
  logic                 tx_enable;
  logic [64*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_valid, ch_last, ch_ready;
  logic [63:0]          data_out;
  logic                 data_to_send, data_in_ready;
  logic [CH_W-1:0]      burst_ch;
  logic                 burst_sop, burst_eop, busy;

  always #5 user_clk = ~user_clk;

  tx_burst_scheduler #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX)) dut (
    .USER_CLK      (user_clk),
    .SYSTEM_RESET_N(rst_n),
    .TX_ENABLE     (tx_enable),
    .CH_DATA       (ch_data),
    .CH_VALID      (ch_valid),
    .CH_LAST       (ch_last),
    .CH_READY      (ch_ready),
    .DATA_OUT      (data_out),
    .DATA_TO_SEND  (data_to_send),
    .DATA_IN_READY (data_in_ready),
    .BURST_CH      (burst_ch),
    .BURST_SOP     (burst_sop),
    .BURST_EOP     (burst_eop),
    .BUSY          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sources: channel c streams packets of plen[c] words; word w carries its own index.
  int                wcnt [NUM_CH];
  int                pos  [NUM_CH];
  int                plen [NUM_CH];
  int                rx_cnt [NUM_CH];
  logic [NUM_CH-1:0] src_en;
  bit                en_nxt, rdy_nxt, rnd_plen;

  // Reference model: who owns the lane, how many words this burst has moved, who finished last.
  bit m_busy;
  int m_owner, last_owner, bw;

  logic [NUM_CH-1:0] o_ready;
  bit o_dts, o_sop, o_eop, o_busy, e_xfer;
  int o_ch;

  function automatic logic [63:0] src_word(input int c, input int w);
    return {16'hDA7A, c[15:0], w[31:0]};
  endfunction

  task automatic drive_inputs();
    tx_enable     = en_nxt;
    data_in_ready = rdy_nxt;
    ch_valid      = src_en;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_data[64*c +: 64] = src_word(c, wcnt[c]);
      ch_last[c]          = (pos[c] == plen[c] - 1);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en_nxt   = 1'b0;
    rdy_nxt  = 1'b0;
    src_en   = '0;
    rnd_plen = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wcnt[c] = 0; pos[c] = 0; plen[c] = 4; rx_cnt[c] = 0;
    end
    m_busy = 1'b0; m_owner = 0; last_owner = NUM_CH - 1; bw = 0;
    @(negedge user_clk);
    drive_inputs();
    @(negedge user_clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, sample 1 ns later, score, then advance model and sources.
  task automatic cycle();
    logic [NUM_CH-1:0] e_ready;
    bit e_dts, e_sop, e_eop, found;
    @(negedge user_clk);
    drive_inputs();
    #1;
    o_ready = ch_ready; o_dts = data_to_send; o_sop = burst_sop;
    o_eop = burst_eop; o_busy = busy; o_ch = int'(burst_ch);
    e_dts   = m_busy && src_en[m_owner];
    e_xfer  = e_dts && rdy_nxt;
    e_ready = '0;
    if (e_xfer) e_ready[m_owner] = 1'b1;
    e_sop = e_xfer && (bw == 0);
    e_eop = e_xfer && ((pos[m_owner] == plen[m_owner] - 1) || (bw == BURST_MAX - 1));
    check("busy",     64'(o_busy),  64'(m_busy));
    check("burst_ch", 64'(o_ch),    64'(m_owner));
    check("dts",      64'(o_dts),   64'(e_dts));
    check("ch_ready", 64'(o_ready), 64'(e_ready));
    check("sop",      64'(o_sop),   64'(e_sop));
    check("eop",      64'(o_eop),   64'(e_eop));
    check("data_out", data_out,     src_word(m_owner, wcnt[m_owner]));
    if (e_xfer) begin
      check("order", 64'(data_out[31:0]), 64'(rx_cnt[m_owner]));
      rx_cnt[m_owner]++;
    end
    if (!m_busy) begin
      if (en_nxt && src_en != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
          if (!found && src_en[(last_owner + k) % NUM_CH]) begin
            m_owner = (last_owner + k) % NUM_CH;
            found   = 1'b1;
          end
        end
        m_busy = 1'b1; bw = 0;
      end
    end else if (e_xfer) begin
      if (e_eop) begin
        m_busy = 1'b0; last_owner = m_owner;
      end else begin
        bw++;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (o_ready[c]) begin
        wcnt[c]++;
        if (pos[c] == plen[c] - 1) begin
          pos[c] = 0;
          if (rnd_plen) plen[c] = $urandom_range(1, 12);
        end else begin
          pos[c]++;
        end
      end
    end
  endtask

  task automatic wait_rx(input int c, input int n, input string name);
    for (int k = 0; k < 200 && rx_cnt[c] < n; k++) cycle();
    check(name, 64'(rx_cnt[c]), 64'(n));
  endtask

  typedef struct {
    bit                en;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] last;
    bit                rdy;
    logic [NUM_CH-1:0] e_ready;
    bit                e_dts;
    int                e_ch;
    bit                e_sop;
    bit                e_eop;
    bit                e_busy;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [63:0] tpat(input int c);
    return {32'hC0DE_0000, c[31:0]};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] sop_map, eop_map;
    int n_obs, gaps, nb, len, cyc, total;
    int got_ch [8];
    bit saw_eop1, got3, seen_eop;

    //            en    valid    last     rdy   e_ready  dts  ch sop  eop  busy
    tbl[0]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 1'b0, 1'b1};

    // Vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge user_clk);
      for (int c = 0; c < NUM_CH; c++) ch_data[64*c +: 64] = tpat(c);
      tx_enable = tbl[i].en; ch_valid = tbl[i].valid;
      ch_last = tbl[i].last; data_in_ready = tbl[i].rdy;
      #1;
      check($sformatf("T%0d_ready", i), 64'(ch_ready),     64'(tbl[i].e_ready));
      check($sformatf("T%0d_dts", i),   64'(data_to_send), 64'(tbl[i].e_dts));
      check($sformatf("T%0d_ch", i),    64'(burst_ch),     64'(tbl[i].e_ch));
      check($sformatf("T%0d_sop", i),   64'(burst_sop),    64'(tbl[i].e_sop));
      check($sformatf("T%0d_eop", i),   64'(burst_eop),    64'(tbl[i].e_eop));
      check($sformatf("T%0d_busy", i),  64'(busy),         64'(tbl[i].e_busy));
      check($sformatf("T%0d_dout", i),  data_out,          tpat(tbl[i].e_ch));
    end

    // 20-word packet on ch0 splits into 8/8/4 bursts
    do_reset();
    plen[0] = 20; src_en = 4'b0001; en_nxt = 1'b1; rdy_nxt = 1'b1;
    sop_map = '0; eop_map = '0; n_obs = 0; gaps = 0;
    for (int k = 0; k < 100 && n_obs < 20; k++) begin
      cycle();
      if (o_dts && rdy_nxt) begin
        n_obs++;
        sop_map[n_obs-1] = o_sop;
        eop_map[n_obs-1] = o_eop;
      end else if (!o_busy && n_obs > 0) begin
        gaps++;
      end
    end
    src_en = '0;
    check("A_words", 64'(n_obs), 64'd20);
    check("A_sop_map", 64'(sop_map), 64'h0001_0101);
    check("A_eop_map", 64'(eop_map), 64'h0008_8080);
    check("A_bubbles", 64'(gaps), 64'd2);

    // All channels valid with 3-word packets: strict rotation
    do_reset();
    for (int c = 0; c < NUM_CH; c++) plen[c] = 3;
    src_en = 4'b1111; en_nxt = 1'b1; rdy_nxt = 1'b1;
    nb = 0; len = 0;
    for (int k = 0; k < 100 && nb < 8; k++) begin
      cycle();
      if (o_dts && rdy_nxt) begin
        if (o_sop) begin
          len = 0;
          got_ch[nb] = o_ch;
        end
        len++;
        if (o_eop) begin
          check("B_len", 64'(len), 64'd3);
          nb++;
        end
      end
    end
    check("B_bursts", 64'(nb), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("B_order%0d", i), 64'(got_ch[i]), 64'(i % NUM_CH));

    // 1000-word ch2 stream under the framer back-pressure pattern
    do_reset();
    plen[2] = 1000; src_en = 4'b0100; en_nxt = 1'b1;
    n_obs = 0; cyc = 0;
    while (n_obs < 1000 && cyc < 4000) begin
      rdy_nxt = !(((cyc % 67) < 3) || ((cyc % 16) < 2));
      cycle();
      cyc++;
      if (o_dts && rdy_nxt) n_obs++;
    end
    check("C_words", 64'(n_obs), 64'd1000);
    check("C_accepted", 64'(wcnt[2]), 64'd1000);
    check("C_received", 64'(rx_cnt[2]), 64'd1000);

    // ch1 pauses mid-burst; waiting ch3 must not take over
    do_reset();
    plen[1] = 8; plen[3] = 4; src_en = 4'b1010; en_nxt = 1'b1; rdy_nxt = 1'b1;
    wait_rx(1, 3, "D_first_words");
    src_en[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("D_pause_dts", 64'(o_dts), 64'd0);
      check("D_pause_ch", 64'(o_ch), 64'd1);
    end
    src_en[1] = 1'b1;
    saw_eop1 = 1'b0; got3 = 1'b0;
    for (int k = 0; k < 40 && !got3; k++) begin
      cycle();
      if (o_eop && o_ch == 1) saw_eop1 = 1'b1;
      if (o_sop && o_ch == 3) got3 = 1'b1;
    end
    check("D_ch3_granted", 64'(got3), 64'd1);
    check("D_ch1_eop_first", 64'(saw_eop1), 64'd1);
    check("D_ch1_words", 64'(rx_cnt[1]), 64'd8);

    // TX_ENABLE drops at word 3: burst runs to word 8, then no new grant
    do_reset();
    plen[0] = 8; src_en = 4'b0001; en_nxt = 1'b1; rdy_nxt = 1'b1;
    wait_rx(0, 3, "E_first_words");
    en_nxt = 1'b0;
    seen_eop = 1'b0;
    for (int k = 0; k < 30 && !seen_eop; k++) begin
      cycle();
      if (o_eop) seen_eop = 1'b1;
    end
    check("E_eop_seen", 64'(seen_eop), 64'd1);
    check("E_eop_word", 64'(rx_cnt[0]), 64'd8);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("E_idle_busy", 64'(o_busy), 64'd0);
    end
    en_nxt = 1'b1;
    cycle();
    cycle();
    check("E_regrant", 64'(o_busy), 64'd1);

    // Asynchronous reset during word 5 of a ch2 burst
    do_reset();
    plen[2] = 20; src_en = 4'b0100; en_nxt = 1'b1; rdy_nxt = 1'b1;
    wait_rx(2, 4, "F_first_words");
    @(negedge user_clk);
    drive_inputs();
    #1;
    check("F_pre_busy", 64'(busy), 64'd1);
    check("F_pre_ch", 64'(burst_ch), 64'd2);
    rst_n = 1'b0;
    #1;
    check("F_rst_ready", 64'(ch_ready), 64'd0);
    check("F_rst_dts", 64'(data_to_send), 64'd0);
    check("F_rst_sop", 64'(burst_sop), 64'd0);
    check("F_rst_eop", 64'(burst_eop), 64'd0);
    check("F_rst_ch", 64'(burst_ch), 64'd0);
    check("F_rst_busy", 64'(busy), 64'd0);
    check("F_rst_dout", data_out, src_word(0, wcnt[0]));
    do_reset();
    src_en = 4'b0101; en_nxt = 1'b1; rdy_nxt = 1'b1;
    got3 = 1'b0;
    for (int k = 0; k < 10 && !got3; k++) begin
      cycle();
      if (o_sop) begin
        got3 = 1'b1;
        check("F_first_grant", 64'(o_ch), 64'd0);
      end
    end
    check("F_granted", 64'(got3), 64'd1);

    // Randomized traffic against the reference model
    do_reset();
    rnd_plen = 1'b1;
    for (int c = 0; c < NUM_CH; c++) plen[c] = $urandom_range(1, 12);
    en_nxt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) src_en[c] = ($urandom_range(0, 9) < 7);
      rdy_nxt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) en_nxt = !en_nxt;
      cycle();
    end
    total = 0;
    for (int c = 0; c < NUM_CH; c++) total += rx_cnt[c];
    check("R_progress", 64'(total > 500), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
